// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt prioritiser and flush/redirect sequencer for CP0
module exc_ctrl #(
  parameter logic [4:0] EC_NONE      = 5'h10,
  parameter logic [4:0] EC_ERET      = 5'h11,
  parameter int         JUMP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        in_delay_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mem_addr_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic [5:0]  int_i,
  input  logic        int_time_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        exc_jump_flag_i,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        in_delay_o,
  output logic        pipe_flush_o,
  output logic        busy_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [5:0]  sync1, sync2;
  logic [7:0]  ip;
  logic        int_pend, req, issue;
  logic [4:0]  sel_code;
  logic [31:0] sel_badv;
  logic        unused_ok;
  assign unused_ok = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};
  // two-flop synchroniser for the asynchronous hardware interrupt lines
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_i;
      sync2 <= sync1;
    end
  // pending interrupt and fixed-priority cause selection
  always_comb begin
    ip       = {sync2[5] | int_time_i, sync2[4:0], cause_i[9:8]};
    int_pend = |(ip & status_i[15:8]) && status_i[0] && !status_i[1];
    req      = int_pend | adel_if_i | ri_i | ov_i | syscall_i | break_i | adel_ld_i | ades_st_i | eret_i;
    sel_code = int_pend  ? 5'h00 :
               adel_if_i ? 5'h04 :
               ri_i      ? 5'h0a :
               ov_i      ? 5'h0c :
               syscall_i ? 5'h08 :
               break_i   ? 5'h09 :
               adel_ld_i ? 5'h04 :
               ades_st_i ? 5'h05 : EC_ERET;
    sel_badv = int_pend ? 32'h0 :
               adel_if_i ? pc_i :
               (ri_i | ov_i | syscall_i | break_i) ? 32'h0 :
               (adel_ld_i | ades_st_i) ? mem_addr_i : 32'h0;
    issue    = (state == IDLE) && valid_i && !stall_i && req;
  end
  // sequencer: issue one-cycle request, flush until CP0 redirects or the wait times out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      exc_code_o     <= EC_NONE;
      exc_epc_o      <= '0;
      exc_badvaddr_o <= '0;
      in_delay_o     <= 1'b0;
      pipe_flush_o   <= 1'b0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      exc_code_o <= EC_NONE;
      case (state)
        IDLE:
          if (issue) begin
            state          <= FLUSH;
            cnt            <= '0;
            exc_code_o     <= sel_code;
            exc_epc_o      <= in_delay_i ? pc_i - 32'd4 : pc_i;
            exc_badvaddr_o <= sel_badv;
            in_delay_o     <= in_delay_i;
            pipe_flush_o   <= 1'b1;
            busy_o         <= 1'b1;
          end
        FLUSH:
          if (exc_jump_flag_i) begin
            state        <= RECOVER;
            pipe_flush_o <= 1'b0;
          end else if (cnt == 4'(JUMP_TIMEOUT - 1)) begin
            state        <= IDLE;
            pipe_flush_o <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b1;
          end else
            cnt <= cnt + 4'd1;
        RECOVER: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          pipe_flush_o <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a behavioural model
module tb_exc_ctrl;
  localparam logic [4:0] NONE = 5'h10, ERET = 5'h11;
  logic clk = 0, rst = 0;
  logic valid_i, stall_i, in_delay_i;
  logic [31:0] pc_i, mem_addr_i, status_i, cause_i;
  logic adel_if_i, ri_i, ov_i, syscall_i, break_i, eret_i, adel_ld_i, ades_st_i;
  logic [5:0] int_i;
  logic int_time_i, exc_jump_flag_i;
  logic [4:0] exc_code_o;
  logic [31:0] exc_epc_o, exc_badvaddr_o;
  logic in_delay_o, pipe_flush_o, busy_o, timeout_o;
  int vecs = 0, errs = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .in_delay_i(in_delay_i),
    .pc_i(pc_i), .mem_addr_i(mem_addr_i), .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i),
    .syscall_i(syscall_i), .break_i(break_i), .eret_i(eret_i), .adel_ld_i(adel_ld_i),
    .ades_st_i(ades_st_i), .int_i(int_i), .int_time_i(int_time_i), .status_i(status_i),
    .cause_i(cause_i), .exc_jump_flag_i(exc_jump_flag_i), .exc_code_o(exc_code_o),
    .exc_epc_o(exc_epc_o), .exc_badvaddr_o(exc_badvaddr_o), .in_delay_o(in_delay_o),
    .pipe_flush_o(pipe_flush_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {valid_i, stall_i, in_delay_i, adel_if_i, ri_i, ov_i, syscall_i, break_i} = '0;
    {eret_i, adel_ld_i, ades_st_i, int_time_i, exc_jump_flag_i} = '0;
    pc_i = 0; mem_addr_i = 0; status_i = 0; cause_i = 0; int_i = 0;
  endtask

  task automatic redirect();
    exc_jump_flag_i = 1;
    step();
    exc_jump_flag_i = 0;
    step();
  endtask

  task automatic test_reset();
    clr();
    rst = 1;
    step();
    vecs++;
    if ({exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, pipe_flush_o, busy_o, timeout_o} !== {NONE, 32'h0, 32'h0, 4'h0}) begin
      $display("FAIL reset: got code=%h epc=%h bad=%h dly/flush/busy/tmo=%b%b%b%b, want 10/0/0/0000",
               exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, pipe_flush_o, busy_o, timeout_o);
      errs++;
    end
    rst = 0;
    step();
  endtask

  task automatic test_ri();
    clr(); valid_i = 1; ri_i = 1; pc_i = 32'h8000_0100;
    step();
    vecs++;
    if ({exc_code_o, exc_epc_o, pipe_flush_o, busy_o} !== {5'h0a, 32'h8000_0100, 2'b11}) begin
      $display("FAIL ri_issue: got code=%h epc=%h flush=%b busy=%b, want 0a 80000100 1 1", exc_code_o, exc_epc_o, pipe_flush_o, busy_o);
      errs++;
    end
    clr();
    step();
    vecs++;
    if ({exc_code_o, pipe_flush_o} !== {NONE, 1'b1}) begin
      $display("FAIL ri_pulse: got code=%h flush=%b, want 10 1", exc_code_o, pipe_flush_o);
      errs++;
    end
    redirect();
    vecs++;
    if (busy_o !== 1'b0) begin
      $display("FAIL ri_return: busy=%b want 0", busy_o);
      errs++;
    end
  endtask

  task automatic test_ades();
    clr(); valid_i = 1; ades_st_i = 1; mem_addr_i = 32'h0000_1003; pc_i = 32'h8000_0200; in_delay_i = 1;
    step();
    vecs++;
    if ({exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o} !== {5'h05, 32'h8000_01FC, 32'h0000_1003, 1'b1}) begin
      $display("FAIL ades: got code=%h epc=%h bad=%h dly=%b, want 05 800001fc 00001003 1", exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o);
      errs++;
    end
    clr();
    redirect();
  endtask

  task automatic test_int_sync();
    clr(); status_i = 32'h0000_1001; int_i = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      step();
      vecs++;
      if ({exc_code_o, busy_o} !== {NONE, 1'b0}) begin
        $display("FAIL int_latency%0d: got code=%h busy=%b, want 10 0", i, exc_code_o, busy_o);
        errs++;
      end
    end
    valid_i = 1; ov_i = 1;
    step();
    vecs++;
    if ({exc_code_o, exc_badvaddr_o, pipe_flush_o} !== {5'h00, 32'h0, 1'b1}) begin
      $display("FAIL int_take: got code=%h bad=%h flush=%b, want 00 0 1", exc_code_o, exc_badvaddr_o, pipe_flush_o);
      errs++;
    end
    clr();
    step(); step(); step();
    redirect();
  endtask

  task automatic test_eret();
    clr(); valid_i = 1; eret_i = 1;
    step();
    vecs++;
    if ({exc_code_o, pipe_flush_o, busy_o} !== {ERET, 2'b11}) begin
      $display("FAIL eret_issue: got code=%h flush=%b busy=%b, want 11 1 1", exc_code_o, pipe_flush_o, busy_o);
      errs++;
    end
    clr();
    step();
    vecs++;
    if ({exc_code_o, pipe_flush_o, busy_o} !== {NONE, 2'b11}) begin
      $display("FAIL eret_flush2: got code=%h flush=%b busy=%b, want 10 1 1", exc_code_o, pipe_flush_o, busy_o);
      errs++;
    end
    exc_jump_flag_i = 1;
    step();
    vecs++;
    if ({pipe_flush_o, busy_o} !== 2'b01) begin
      $display("FAIL eret_recover: got flush=%b busy=%b, want 0 1", pipe_flush_o, busy_o);
      errs++;
    end
    exc_jump_flag_i = 0; valid_i = 1; syscall_i = 1;
    step();
    clr();
    vecs++;
    if ({exc_code_o, pipe_flush_o, busy_o} !== {NONE, 2'b00}) begin
      $display("FAIL eret_sys_ignored: got code=%h flush=%b busy=%b, want 10 0 0", exc_code_o, pipe_flush_o, busy_o);
      errs++;
    end
    step();
    vecs++;
    if ({exc_code_o, busy_o} !== {NONE, 1'b0}) begin
      $display("FAIL eret_idle: got code=%h busy=%b, want 10 0", exc_code_o, busy_o);
      errs++;
    end
  endtask

  task automatic test_timeout();
    clr(); valid_i = 1; syscall_i = 1;
    step();
    clr();
    for (int i = 0; i < 8; i++) begin
      step();
      vecs++;
      if ({pipe_flush_o, busy_o, timeout_o} !== ((i < 7) ? 3'b110 : 3'b001)) begin
        $display("FAIL timeout_cycle%0d: got flush/busy/tmo=%b%b%b, want %b", i, pipe_flush_o, busy_o, timeout_o, (i < 7) ? 3'b110 : 3'b001);
        errs++;
      end
    end
    valid_i = 1; break_i = 1;
    step();
    clr();
    redirect();
    vecs++;
    if ({busy_o, timeout_o} !== 2'b01) begin
      $display("FAIL timeout_sticky: got busy=%b tmo=%b, want 0 1", busy_o, timeout_o);
      errs++;
    end
    rst = 1;
    #1;
    vecs++;
    if (timeout_o !== 1'b0) begin
      $display("FAIL timeout_clear: tmo=%b want 0", timeout_o);
      errs++;
    end
    rst = 0;
    step();
  endtask

  task automatic test_abort();
    clr(); valid_i = 1; ri_i = 1;
    step();
    step();
    rst = 1;
    #2;
    vecs++;
    if ({exc_code_o, pipe_flush_o, busy_o} !== {NONE, 2'b00}) begin
      $display("FAIL abort_reset: got code=%h flush=%b busy=%b, want 10 0 0", exc_code_o, pipe_flush_o, busy_o);
      errs++;
    end
    clr();
    rst = 0;
    step(); step();
    vecs++;
    if ({exc_code_o, busy_o} !== {NONE, 1'b0}) begin
      $display("FAIL abort_quiet: got code=%h busy=%b, want 10 0", exc_code_o, busy_o);
      errs++;
    end
  endtask

  task automatic test_stall();
    clr(); valid_i = 1; stall_i = 1; break_i = 1;
    step(); step();
    vecs++;
    if ({exc_code_o, busy_o} !== {NONE, 1'b0}) begin
      $display("FAIL stall_hold: got code=%h busy=%b, want 10 0", exc_code_o, busy_o);
      errs++;
    end
    stall_i = 0;
    step();
    vecs++;
    if ({exc_code_o, busy_o} !== {5'h09, 1'b1}) begin
      $display("FAIL stall_release: got code=%h busy=%b, want 09 1", exc_code_o, busy_o);
      errs++;
    end
    clr();
    redirect();
  endtask

  task automatic test_random();
    logic f[8];
    logic [4:0] cd[8];
    logic [7:0] im;
    logic [1:0] sw;
    logic ie, exl, pend, req, tmo;
    logic [4:0] ecode;
    logic [31:0] ebad, eepc;
    int first, j;
    cd = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, ERET};
    tmo = 0;
    for (int n = 0; n < 80; n++) begin
      clr();
      for (int k = 0; k < 8; k++) f[k] = ($urandom_range(0, 3) == 0);
      im = 8'($urandom); sw = 2'($urandom); ie = 1'($urandom); exl = 1'($urandom);
      pc_i = $urandom; mem_addr_i = $urandom; in_delay_i = 1'($urandom);
      status_i = {16'h0, im, 6'h0, exl, ie};
      cause_i = {22'h0, sw, 8'h0};
      {adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_ld_i, ades_st_i, eret_i} = {f[0], f[1], f[2], f[3], f[4], f[5], f[6], f[7]};
      valid_i = 1;
      pend = ((sw & im[1:0]) != 0) && ie && !exl;
      first = -1;
      for (int k = 7; k >= 0; k--) if (f[k]) first = k;
      req = pend || first >= 0;
      ecode = pend ? 5'h00 : (first >= 0) ? cd[first] : NONE;
      ebad = (pend || first < 0) ? 32'h0 : (first == 0) ? pc_i : (first >= 5 && first <= 6) ? mem_addr_i : 32'h0;
      eepc = in_delay_i ? pc_i - 32'd4 : pc_i;
      step();
      vecs++;
      if (!req) begin
        if ({exc_code_o, busy_o, pipe_flush_o} !== {NONE, 2'b00}) begin
          $display("FAIL rnd%0d_noreq: got code=%h busy=%b flush=%b, want 10 0 0", n, exc_code_o, busy_o, pipe_flush_o);
          errs++;
        end
        continue;
      end
      if ({exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, pipe_flush_o, busy_o, timeout_o} !== {ecode, eepc, ebad, in_delay_i, 2'b11, tmo}) begin
        $display("FAIL rnd%0d_issue: got code=%h epc=%h bad=%h dly=%b flush=%b busy=%b tmo=%b, want %h %h %h %b 1 1 %b",
                 n, exc_code_o, exc_epc_o, exc_badvaddr_o, in_delay_o, pipe_flush_o, busy_o, timeout_o, ecode, eepc, ebad, in_delay_i, tmo);
        errs++;
      end
      j = $urandom_range(0, 9);
      for (int c = 0; c < 8; c++) begin
        if (c == ((j < 7) ? j : 7)) clr();
        exc_jump_flag_i = (c == j);
        step();
        vecs++;
        if (c == j) begin
          if ({exc_code_o, pipe_flush_o, busy_o} !== {NONE, 2'b01}) begin
            $display("FAIL rnd%0d_recover: got code=%h flush=%b busy=%b, want 10 0 1", n, exc_code_o, pipe_flush_o, busy_o);
            errs++;
          end
          exc_jump_flag_i = 0;
          step();
          vecs++;
          if ({busy_o, pipe_flush_o, timeout_o} !== {2'b00, tmo}) begin
            $display("FAIL rnd%0d_idle: got busy=%b flush=%b tmo=%b, want 0 0 %b", n, busy_o, pipe_flush_o, timeout_o, tmo);
            errs++;
          end
          break;
        end else if (c == 7) begin
          tmo = 1;
          if ({busy_o, pipe_flush_o, timeout_o} !== 3'b001) begin
            $display("FAIL rnd%0d_timeout: got busy=%b flush=%b tmo=%b, want 0 0 1", n, busy_o, pipe_flush_o, timeout_o);
            errs++;
          end
        end else if ({exc_code_o, pipe_flush_o, busy_o} !== {NONE, 2'b11}) begin
          $display("FAIL rnd%0d_flush%0d: got code=%h flush=%b busy=%b, want 10 1 1", n, c, exc_code_o, pipe_flush_o, busy_o);
          errs++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ri();
    test_ades();
    test_int_sync();
    test_eret();
    test_stall();
    test_timeout();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
